// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - multicycle controller state encodings, mux select codes and control word
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [1:0] SRCA_REG     = 2'b00;
  localparam logic [1:0] SRCA_PC      = 2'b01;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_IMM     = 2'b01;
  localparam logic [1:0] SRCB_FOUR    = 2'b10;

  localparam logic [1:0] RES_ALUOUT   = 2'b00;
  localparam logic [1:0] RES_READDATA = 2'b01;
  localparam logic [1:0] RES_ALU      = 2'b10;

  localparam logic [1:0] OP_DP        = 2'b00;
  localparam logic [1:0] OP_MEM       = 2'b01;
  localparam logic [1:0] OP_BR        = 2'b10;
  localparam logic [1:0] OP_UNDEF     = 2'b11;

  typedef struct packed {
    logic       irwrite;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       adrsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       aluop;
    logic       instrdone;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/main_fsm_if.sv
// rtl/main_fsm_if.sv - controller <-> datapath/memory signal bundle
interface main_fsm_if;

  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReady;

  logic       IRWrite;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       AdrSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       ALUOp;
  logic       InstrDone;
  logic       Undef;
  logic [3:0] State;

  modport master (
    input  Op, Funct, MemReady,
    output IRWrite, NextPC, RegW, MemW, Branch, AdrSrc,
    output ALUSrcA, ALUSrcB, ResultSrc, ALUOp, InstrDone, Undef, State
  );

  modport slave (
    output Op, Funct, MemReady,
    input  IRWrite, NextPC, RegW, MemW, Branch, AdrSrc,
    input  ALUSrcA, ALUSrcB, ResultSrc, ALUOp, InstrDone, Undef, State
  );

endinterface

// File: rtl/main_fsm_outdec.sv
// rtl/main_fsm_outdec.sv - Moore output decode from state (plus memory handshake qualification)
module main_fsm_outdec
  import mc_pkg::*;
(
  input  logic [3:0] State,
  input  logic       MemReady,
  input  logic       reset,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = CTRL_IDLE;
    case (State)
      S_FETCH: begin
        ctrl.irwrite   = MemReady;
        ctrl.nextpc    = MemReady;
        ctrl.alusrca   = SRCA_PC;
        ctrl.alusrcb   = SRCB_FOUR;
        ctrl.resultsrc = RES_ALU;
      end
      S_DECODE: begin
        ctrl.alusrca   = SRCA_PC;
        ctrl.alusrcb   = SRCB_FOUR;
        ctrl.resultsrc = RES_ALU;
      end
      S_MEMADR: begin
        ctrl.alusrca   = SRCA_REG;
        ctrl.alusrcb   = SRCB_IMM;
      end
      S_MEMREAD: begin
        ctrl.adrsrc    = 1'b1;
        ctrl.resultsrc = RES_ALUOUT;
      end
      S_MEMWRITE: begin
        ctrl.adrsrc    = 1'b1;
        ctrl.resultsrc = RES_ALUOUT;
        ctrl.memw      = 1'b1;
        ctrl.instrdone = MemReady;
      end
      S_MEMWB: begin
        ctrl.resultsrc = RES_READDATA;
        ctrl.regw      = 1'b1;
        ctrl.instrdone = 1'b1;
      end
      S_EXECUTER: begin
        ctrl.alusrca   = SRCA_REG;
        ctrl.alusrcb   = SRCB_REG;
        ctrl.aluop     = 1'b1;
      end
      S_EXECUTEI: begin
        ctrl.alusrca   = SRCA_REG;
        ctrl.alusrcb   = SRCB_IMM;
        ctrl.aluop     = 1'b1;
      end
      S_ALUWB: begin
        ctrl.resultsrc = RES_ALUOUT;
        ctrl.regw      = 1'b1;
        ctrl.instrdone = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca   = SRCA_REG;
        ctrl.alusrcb   = SRCB_IMM;
        ctrl.resultsrc = RES_ALU;
        ctrl.branch    = 1'b1;
        ctrl.instrdone = 1'b1;
      end
      default: ctrl = CTRL_IDLE;
    endcase

    // State is already FETCH during reset; only the strobes need gating.
    if (!reset) begin
      ctrl.irwrite   = 1'b0;
      ctrl.nextpc    = 1'b0;
      ctrl.regw      = 1'b0;
      ctrl.memw      = 1'b0;
      ctrl.branch    = 1'b0;
      ctrl.instrdone = 1'b0;
    end
  end

endmodule

// File: rtl/main_fsm.sv
// rtl/main_fsm.sv - multicycle processor main controller: state register and next-state logic
module main_fsm
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  main_fsm_if.master bus
);

  state_t state;
  state_t state_next;
  ctrl_t  ctrl;
  logic   unused_funct;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Op/Funct are only looked at in DECODE and MEMADR.
  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:    state_next = bus.MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.Op)
          OP_MEM:  state_next = S_MEMADR;
          OP_DP:   state_next = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_next = S_BRANCH;
          default: state_next = S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = bus.Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_next = bus.MemReady ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_next = bus.MemReady ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_next = S_ALUWB;
      S_EXECUTEI: state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_MEMWB:    state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      default:    state_next = S_FETCH;
    endcase
  end

  main_fsm_outdec u_outdec (
    .State    (state),
    .MemReady (bus.MemReady),
    .reset    (reset),
    .ctrl     (ctrl)
  );

  assign bus.IRWrite   = ctrl.irwrite;
  assign bus.NextPC    = ctrl.nextpc;
  assign bus.RegW      = ctrl.regw;
  assign bus.MemW      = ctrl.memw;
  assign bus.Branch    = ctrl.branch;
  assign bus.AdrSrc    = ctrl.adrsrc;
  assign bus.ALUSrcA   = ctrl.alusrca;
  assign bus.ALUSrcB   = ctrl.alusrcb;
  assign bus.ResultSrc = ctrl.resultsrc;
  assign bus.ALUOp     = ctrl.aluop;
  assign bus.InstrDone = ctrl.instrdone;
  assign bus.Undef     = reset && (state == S_DECODE) && (bus.Op == OP_UNDEF);
  assign bus.State     = state;

  assign unused_funct  = ^bus.Funct[4:1];

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, rising-edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: Op  in  2  instruction class (00 data-proc, 01 memory, 10 branch, 11 undefined).
REQ-004 SHALL have ports: Funct  in  6  instruction Funct field; Funct[5]=immediate, Funct[0]=load/S bit.
REQ-005 SHALL have ports: MemReady  in  1  memory completes the current access this cycle.
REQ-006 SHALL have ports: IRWrite  out  1  load instruction register.
REQ-007 SHALL have ports: NextPC  out  1  PC update strobe.
REQ-008 SHALL have ports: RegW  out  1  register write request, pre-condition-check.
REQ-009 SHALL have ports: MemW  out  1  memory write request, pre-condition-check.
REQ-010 SHALL have ports: Branch  out  1  branch request, pre-condition-check.
REQ-011 SHALL have ports: AdrSrc  out  1  0=PC, 1=ALU result to memory address.
REQ-012 SHALL have ports: ALUSrcA  out  2  00=RegA, 01=PC.
REQ-013 SHALL have ports: ALUSrcB  out  2  00=RegB, 01=ExtImm, 10=constant 4.
REQ-014 SHALL have ports: ResultSrc  out  2  00=ALUOut, 01=ReadData, 10=ALU result.
REQ-015 SHALL have ports: ALUOp  out  1  1=decode Funct for ALU, 0=add.
REQ-016 SHALL have ports: InstrDone  out  1  one-cycle pulse in final state of each instruction.
REQ-017 SHALL have ports: Undef  out  1  one-cycle pulse on undefined Op in DECODE.
REQ-018 SHALL have ports: State  out  4  current state encoding, for debug.

Function
REQ-019 SHALL implement a Moore FSM; states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
REQ-020 SHALL use these transitions: FETCH->DECODE only if MemReady=1, else hold FETCH.
REQ-021 SHALL use these transitions from DECODE: Op=01->MEMADR; Op=00,Funct[5]=0->EXECUTER; Op=00,Funct[5]=1->EXECUTEI; Op=10->BRANCH; Op=11->FETCH with Undef=1 that cycle.
REQ-022 SHALL use these transitions: MEMADR->MEMREAD if Funct[0]=1, else MEMWRITE.
REQ-023 SHALL use these transitions: MEMREAD->MEMWB and MEMWRITE->FETCH only if MemReady=1, else hold.
REQ-024 SHALL use these transitions: EXECUTER/EXECUTEI->ALUWB; ALUWB, MEMWB, BRANCH->FETCH.
REQ-025 SHALL drive FETCH: IRWrite=1, NextPC=1 only while MemReady=1; AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ALUOp=0, ResultSrc=10.
REQ-026 SHALL drive DECODE: ALUSrcA=01, ALUSrcB=10, ALUOp=0, ResultSrc=10.
REQ-027 SHALL drive MEMADR: ALUSrcA=00, ALUSrcB=01, ALUOp=0.
REQ-028 SHALL drive MEMREAD: AdrSrc=1, ResultSrc=00.
REQ-029 SHALL drive MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1.
REQ-030 SHALL drive MEMWB: ResultSrc=01, RegW=1.
REQ-031 SHALL drive EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1. EXECUTEI: same with ALUSrcB=01.
REQ-032 SHALL drive ALUWB: ResultSrc=00, RegW=1.
REQ-033 SHALL drive BRANCH: ALUSrcA=00, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=1.
REQ-034 SHALL drive every field not listed for a state to 0.
REQ-035 SHALL assert InstrDone in ALUWB, MEMWB, BRANCH, and in MEMWRITE when MemReady=1.
REQ-036 SHALL treat illegal State encodings as FETCH next cycle, with all strobes 0.
REQ-037 SHALL sample Op/Funct only in DECODE and MEMADR; changes in other states SHALL have no effect.

Reset
REQ-038 SHALL enter FETCH asynchronously when reset=0.
REQ-039 SHALL force IRWrite, NextPC, RegW, MemW, Branch, InstrDone, Undef to 0 while reset=0; mux selects take FETCH values.
REQ-040 SHALL resume at FETCH on the first rising clk after reset deasserts, mid-instruction state discarded.

Structure
REQ-041 SHALL take state encodings and ALUSrcA/ALUSrcB/ResultSrc codes from shared package mc_pkg.
REQ-042 SHALL split combinational output decode into one sub-module main_fsm_outdec (State, MemReady, reset in; control word out).

Verification
REQ-043 SHALL test: ADD reg, Op=00, Funct=000000, MemReady=1 -> FETCH,DECODE,EXECUTER,ALUWB; RegW=1 in cycle 4; InstrDone pulse.
REQ-044 SHALL test: LDR, Op=01, Funct=011001, MemReady low 2 cycles in MEMREAD -> MEMREAD held 3 cycles, then MEMWB RegW=1, ResultSrc=01.
REQ-045 SHALL test: STR, Op=01, Funct=011000 -> MEMWRITE MemW=1, AdrSrc=1; InstrDone only with MemReady=1.
REQ-046 SHALL test: B, Op=10 -> BRANCH, Branch=1, ALUSrcB=01; then FETCH.
REQ-047 SHALL test: Op=11 -> Undef pulse in DECODE, return to FETCH, no RegW/MemW.
REQ-048 SHALL test: reset=0 asserted in MEMREAD -> immediate FETCH, strobes 0; first post-reset fetch IRWrite=1 with MemReady=1.
